// File: rtl/spi_master.sv
// SPI mode-0 master: MSB-first 8-bit frames, single active-low slave select.
// Define SPI_MASTER_BURST_EN to add the hold input, which keeps ss low across consecutive frames.
module spi_master #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] din,
`ifdef SPI_MASTER_BURST_EN
    input  logic       hold,
`endif
    output logic       busy,
    output logic       done,
    output logic [7:0] dout,
    output logic       ss,
    output logic       sck,
    output logic       mosi,
    input  logic       miso
);

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StXfer,
        StHold,
        StGap
`ifdef SPI_MASTER_BURST_EN
        , StWait
`endif
    } state_e;

    state_e     state;
    logic [7:0] div_cnt;
    logic [3:0] bit_cnt;
    logic [7:0] shift;
    logic       wrap;

    assign wrap = (div_cnt == 8'(CLK_DIV - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= StIdle;
            div_cnt <= '0;
            bit_cnt <= '0;
            shift   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            dout    <= 8'h00;
            ss      <= 1'b1;
            sck     <= 1'b0;
            mosi    <= 1'b1;
        end else begin
            done    <= 1'b0;
            div_cnt <= wrap ? '0 : div_cnt + 8'd1;
            unique case (state)
                StIdle: begin
                    div_cnt <= '0;
                    if (start) begin
                        shift   <= din;
                        ss      <= 1'b0;
                        mosi    <= din[7];
                        busy    <= 1'b1;
                        bit_cnt <= '0;
                        state   <= StSetup;
                    end
                end
                StSetup: begin
                    // First rising edge also samples the first miso bit
                    if (wrap) begin
                        sck     <= 1'b1;
                        shift   <= {shift[6:0], miso};
                        bit_cnt <= bit_cnt + 4'd1;
                        state   <= StXfer;
                    end
                end
                StXfer: begin
                    if (wrap) begin
                        if (sck) begin
                            sck  <= 1'b0;
                            mosi <= shift[7];
                            if (bit_cnt == 4'd8) begin
                                state <= StHold;
                            end
                        end else begin
                            sck     <= 1'b1;
                            shift   <= {shift[6:0], miso};
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                end
                StHold: begin
                    if (wrap) begin
                        done <= 1'b1;
                        dout <= shift;
                        mosi <= 1'b1;
`ifdef SPI_MASTER_BURST_EN
                        if (hold) begin
                            busy  <= 1'b0;
                            state <= StWait;
                        end else begin
                            ss    <= 1'b1;
                            state <= StGap;
                        end
`else
                        ss    <= 1'b1;
                        state <= StGap;
`endif
                    end
                end
                StGap: begin
                    if (wrap) begin
                        busy  <= 1'b0;
                        state <= StIdle;
                    end
                end
`ifdef SPI_MASTER_BURST_EN
                StWait: begin
                    // ss stays low; the next frame starts without an ss edge
                    div_cnt <= '0;
                    if (start) begin
                        shift   <= din;
                        mosi    <= din[7];
                        busy    <= 1'b1;
                        bit_cnt <= '0;
                        state   <= StSetup;
                    end else if (!hold) begin
                        ss    <= 1'b1;
                        busy  <= 1'b1;
                        state <= StGap;
                    end
                end
`endif
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// Scoreboard bench for spi_master: two instances (CLK_DIV 4 and 6) share one behavioural slave.
`timescale 1ns/1ps
module tb_spi_master;

    localparam int unsigned DIV_A = 4;
    localparam int unsigned DIV_B = 6;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start_a = 1'b0;
    logic       start_b = 1'b0;
    logic [7:0] din = 8'h00;
    logic       miso;
    logic       busy_a, done_a, ss_a, sck_a, mosi_a;
    logic       busy_b, done_b, ss_b, sck_b, mosi_b;
    logic [7:0] dout_a, dout_b;
`ifdef SPI_MASTER_BURST_EN
    logic       hold = 1'b0;
`endif

    always #5 clk = ~clk;

    spi_master #(.CLK_DIV(DIV_A)) u_dut_a (
        .clk(clk), .rst(rst), .start(start_a), .din(din),
`ifdef SPI_MASTER_BURST_EN
        .hold(hold),
`endif
        .busy(busy_a), .done(done_a), .dout(dout_a),
        .ss(ss_a), .sck(sck_a), .mosi(mosi_a), .miso(miso)
    );

    spi_master #(.CLK_DIV(DIV_B)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b), .din(din),
`ifdef SPI_MASTER_BURST_EN
        .hold(1'b0),
`endif
        .busy(busy_b), .done(done_b), .dout(dout_b),
        .ss(ss_b), .sck(sck_b), .mosi(mosi_b), .miso(miso)
    );

    // The unselected instance is always idle, so switching sel causes no edges.
    logic       sel = 1'b0;
    logic       ss_m, sck_m, mosi_m, busy_m, done_m;
    logic [7:0] dout_m;
    assign ss_m   = sel ? ss_b   : ss_a;
    assign sck_m  = sel ? sck_b  : sck_a;
    assign mosi_m = sel ? mosi_b : mosi_a;
    assign busy_m = sel ? busy_b : busy_a;
    assign done_m = sel ? done_b : done_a;
    assign dout_m = sel ? dout_b : dout_a;

    typedef struct {
        logic [7:0] data;
        int         done_at;
        int         busy_at;
    } exp_t;

    exp_t       mq[$];
    logic [7:0] sq[$];
    logic [7:0] slv_tx_q[$];
    int         win_q[$];

    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    logic burst_active = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name, input logic [31:0] act);
        vectors++;
        miscompares++;
        $display("FAIL %s: got %0h, expected nothing (cycle %0d)", name, act, cyc);
    endtask

    // Behavioural slave plus output monitor, sampled on the falling clk edge.
    logic [7:0] s_tx, s_rx, exp_byte;
    int         s_bits, rises, last_busy_at;
    logic       ss_p, sck_p, busy_p;
    exp_t       e;

    task automatic slave_load();
        s_tx = (slv_tx_q.size() > 0) ? slv_tx_q.pop_front() : 8'h00;
        miso = s_tx[7];
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            s_bits = 0;
            rises  = 0;
            ss_p   = 1'b1;
            sck_p  = 1'b0;
            busy_p = 1'b0;
            miso   = 1'b0;
        end else begin
            if (ss_p && !ss_m) begin
                rises  = 0;
                s_bits = 0;
                slave_load();
            end
            if (!ss_m && sck_m && !sck_p) begin
                rises++;
                if (sq.size() > 0 && s_bits < 8) begin
                    exp_byte = sq[0];
                    check("mosi_bit", 32'(mosi_m), 32'(exp_byte[7 - s_bits]));
                end
                s_rx = {s_rx[6:0], mosi_m};
                s_bits++;
                if (s_bits == 8) begin
                    if (sq.size() > 0) check("slave_rx", 32'(s_rx), 32'(sq.pop_front()));
                    else fail("slave_rx_unexpected", 32'(s_rx));
                end
            end
            if (!ss_m && !sck_m && sck_p) begin
                if (s_bits >= 8) begin
                    s_bits = 0;
                    if (burst_active && slv_tx_q.size() > 0) slave_load();
                end else begin
                    s_tx = {s_tx[6:0], 1'b0};
                    miso = s_tx[7];
                end
            end
            if (!ss_p && ss_m) begin
                if (win_q.size() > 0) check("sck_rises", 32'(rises), 32'(8 * win_q.pop_front()));
                else fail("ss_window_unexpected", 32'(rises));
            end
            if (done_m) begin
                if (mq.size() > 0) begin
                    e = mq.pop_front();
                    check("dout", 32'(dout_m), 32'(e.data));
                    check("done_time", 32'(cyc), 32'(e.done_at));
                    last_busy_at = e.busy_at;
                end else begin
                    fail("spurious_done", 32'(dout_m));
                end
            end
            if (busy_p && !busy_m && !burst_active)
                check("busy_fall_time", 32'(cyc), 32'(last_busy_at));
            ss_p   = ss_m;
            sck_p  = sck_m;
            busy_p = busy_m;
        end
    end

    // Frame model: ss low at t0+1, done at t0+1+17*D, busy low at t0+1+18*D.
    task automatic issue(input logic [7:0] m, input logic [7:0] s);
        int d;
        exp_t x;
        d = sel ? int'(DIV_B) : int'(DIV_A);
        x.data    = s;
        x.done_at = cyc + 1 + 17 * d;
        x.busy_at = cyc + 1 + 18 * d;
        mq.push_back(x);
        sq.push_back(m);
        if (!burst_active) begin
            slv_tx_q.push_back(s);
            win_q.push_back(1);
        end
        din = m;
        if (sel) start_b = 1'b1;
        else start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        start_b = 1'b0;
        din = 8'($urandom);
    endtask

    task automatic wait_busy_low();
        int n;
        n = 0;
        @(negedge clk);
        while (busy_m !== 1'b0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) fail("busy_timeout", 32'(busy_m));
    endtask

    task automatic wait_idle();
        wait_busy_low();
        @(posedge clk);
        #1;
    endtask

    task automatic flush();
        mq.delete();
        sq.delete();
        slv_tx_q.delete();
        win_q.delete();
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] m, s;
        logic [7:0] pats [4];
        int hi;
        pats[0] = 8'h00; pats[1] = 8'hFF; pats[2] = 8'h80; pats[3] = 8'h01;

        repeat (3) @(posedge clk);
        #1;
        check("rst_ss_a",   32'(ss_a),   32'd1);
        check("rst_sck_a",  32'(sck_a),  32'd0);
        check("rst_mosi_a", 32'(mosi_a), 32'd1);
        check("rst_busy_a", 32'(busy_a), 32'd0);
        check("rst_done_a", 32'(done_a), 32'd0);
        check("rst_dout_a", 32'(dout_a), 32'h00);
        check("rst_ss_b",   32'(ss_b),   32'd1);
        check("rst_sck_b",  32'(sck_b),  32'd0);
        check("rst_busy_b", 32'(busy_b), 32'd0);
        check("rst_dout_b", 32'(dout_b), 32'h00);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Loopback A5 / 3C on CLK_DIV=4
        issue(8'hA5, 8'h3C);
        wait_idle();
        check("idle_mosi", 32'(mosi_m), 32'd1);

        // Pattern sweep in both directions
        for (int i = 0; i < 4; i++) begin
            issue(pats[i], pats[3 - i]);
            wait_idle();
        end

        // start while busy must be ignored
        issue(8'h96, 8'h69);
        repeat (9) @(posedge clk);
        #1;
        din = 8'h55;
        start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        wait_idle();

        // Reset mid-frame at t0+30 aborts without done
        issue(8'h5A, 8'hE7);
        repeat (29) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("abort_ss",   32'(ss_a),   32'd1);
        check("abort_sck",  32'(sck_a),  32'd0);
        check("abort_busy", 32'(busy_a), 32'd0);
        flush();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        issue(8'hC3, 8'h4B);
        wait_idle();

        // Back-to-back on CLK_DIV=6: second start on the first non-busy cycle
        sel = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        issue(8'h12, 8'hA1);
        hi = 0;
        for (int n = 0; n < 400 && busy_m !== 1'b0; n++) begin
            @(negedge clk);
            if (ss_m) hi++;
        end
        issue(8'h34, 8'hB2);
        check("b2b_ss_gap_ok", 32'(hi >= int'(DIV_B)), 32'd1);
        wait_idle();
        check("b2b_dout_hold", 32'(dout_m), 32'hB2);

`ifdef SPI_MASTER_BURST_EN
        // Burst of three frames with hold=1 on CLK_DIV=4
        sel = 1'b0;
        burst_active = 1'b1;
        slv_tx_q.push_back(8'hD1);
        slv_tx_q.push_back(8'hD2);
        slv_tx_q.push_back(8'hD3);
        win_q.push_back(3);
        hold = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        issue(8'h11, 8'hD1);
        wait_busy_low();
        check("burst_ss_low_1", 32'(ss_m), 32'd0);
        issue(8'h22, 8'hD2);
        wait_busy_low();
        check("burst_ss_low_2", 32'(ss_m), 32'd0);
        issue(8'h33, 8'hD3);
        wait_busy_low();
        check("burst_ss_low_3", 32'(ss_m), 32'd0);
        repeat (3) @(negedge clk);
        check("burst_ss_while_hold", 32'(ss_m), 32'd0);
        @(posedge clk);
        #1;
        hold = 1'b0;
        @(negedge clk);
        check("burst_ss_before_release", 32'(ss_m), 32'd0);
        @(negedge clk);
        check("burst_ss_after_release", 32'(ss_m), 32'd1);
        wait_idle();
        repeat (2) @(negedge clk);
        burst_active = 1'b0;
        @(posedge clk);
        #1;
`endif

        // Randomized frames on either instance
        for (int i = 0; i < 16; i++) begin
            sel = 1'($urandom_range(0, 1));
            m = 8'($urandom);
            s = 8'($urandom);
            repeat ($urandom_range(0, 5)) @(posedge clk);
            #1;
            issue(m, s);
            wait_idle();
            repeat ($urandom_range(0, 4)) @(posedge clk);
            #1;
            check("rand_dout_hold", 32'(dout_m), 32'(s));
            check("rand_ss_idle", 32'(ss_m), 32'd1);
        end

        repeat (4) @(posedge clk);
        #1;
        check("mq_drained", 32'(mq.size()), 32'd0);
        check("sq_drained", 32'(sq.size()), 32'd0);
        check("win_drained", 32'(win_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
- SPI mode-0 master (CPOL=0, CPHA=0), MSB first, 8-bit frames, single slave select.
- Drives the SPI slave blocks in this codebase, e.g. FPGA-to-FPGA links and the loopback test bench.
- Takes a byte over a start/busy/done handshake, generates sck/ss/mosi from the system clock, and returns the byte captured on miso.

Parameters:
- CLK_DIV, 4: sck half-period in clk cycles. Legal range is 4..255; values below 4 are illegal because the slave uses a 2-flop input sampling path.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request; sampled only when busy=0.
- din  input  8  byte to transmit; captured in the start cycle.
- busy  output  1  high from the cycle after start is accepted until the frame and guard gap are complete.
- done  output  1  one-cycle pulse; dout is valid on the same cycle.
- dout  output  8  last received byte; holds its value until the next done.
- ss  output  1  slave select, active low.
- sck  output  1  serial clock; idles low.
- mosi  output  1  serial data out.
- miso  input  1  serial data in; sampled on the sck rising edge.

Behaviour:
- Reset (async assert, sync release) values: ss=1, sck=0, mosi=1, busy=0, done=0, dout=8'h00, state=IDLE. Divider counter, bit counter and shift register all clear.
- Reset asserted mid-frame aborts the frame immediately: ss goes high, sck goes low, and no done pulse is produced.
- States: IDLE, SETUP, XFER, HOLD, GAP.
- Divider counter counts 0..CLK_DIV-1. Every state except IDLE advances on counter wrap.
- IDLE, start=1 at cycle t0:
  - shift register <= din
  - ss <= 0, mosi <= din[7], busy <= 1
  - next state SETUP.
- SETUP: after CLK_DIV cycles, sck <= 1 and go to XFER. The first rising edge occurs at t0+1+CLK_DIV.
- XFER: sck toggles on each counter wrap.
  - Rising edge: shift register <= {shift[6:0], miso}, bit counter +1.
  - Falling edge: mosi <= shift[7].
  - After the 8th falling edge (t0+1+16*CLK_DIV), go to HOLD with sck=0.
- HOLD: ss held low for CLK_DIV cycles, then:
  - ss <= 1
  - dout <= shift register
  - done=1 for exactly one cycle, at t0+1+17*CLK_DIV
  - mosi <= 1
  - next state GAP.
- GAP: ss high for CLK_DIV cycles so the slave reloads its transmit byte. busy drops at t0+1+18*CLK_DIV and the state returns to IDLE.
- start while busy=1 is ignored; there is no queueing.
- start on the cycle busy falls is accepted on the following cycle.
- din is don't-care except in the start-accept cycle.
- miso is sampled exactly once per rising edge, on the clk cycle sck goes high. No other miso sampling occurs.
- CLK_DIV=4 frame timing: ss low at t0+1, done at t0+69, busy low at t0+73.

Optional Feature:
- SPI_MASTER_BURST_EN: adds input port hold (1 bit).
- Defined, hold=1 sampled at the end of HOLD:
  - done pulses and dout updates as normal
  - ss stays low and the state moves to WAIT (busy=0)
  - start in WAIT loads din, sets mosi=din[7] and enters SETUP without an ss edge; timing otherwise matches a normal frame
  - hold=0 in WAIT (with no start that cycle) causes ss <= 1 and a move to GAP.
- Undefined: the hold port and the WAIT state are absent, and the block behaves as if hold=0 at all times.

Test Plan:
- Loopback to an SPI slave, CLK_DIV=4, master din=8'hA5, slave din=8'h3C, start at t0:
  - master dout=8'h3C with done at t0+69
  - slave dout=8'hA5 with its done pulse
  - exactly 8 sck rising edges while ss=0.
- Pattern sweep 8'h00, 8'hFF, 8'h80, 8'h01 in both directions -> each received byte matches the sent byte. mosi checked bit-by-bit at each rising edge, MSB first.
- start pulsed at t0+10 during a frame with din=8'h55 -> ignored. The frame still carries the original byte, and only one done is seen.
- rst low at t0+30 mid-frame -> ss=1, sck=0, busy=0 within the same cycle and no done. A fresh 8'hC3 transfer afterwards completes correctly.
- Back-to-back start on the first non-busy cycle, CLK_DIV=6, bytes 8'h12 then 8'h34:
  - ss high for at least 6 cycles between frames
  - both dout values correct.
- With SPI_MASTER_BURST_EN defined, hold=1 across 3 bytes 8'h11/8'h22/8'h33:
  - ss stays low for all 3 frames
  - 3 done pulses
  - slave receives all 3 bytes in order
  - ss rises only after hold drops.
